// File: rtl/alu_share_if.sv
// alu_share_if: request/response bundle between two ALU requesters and the
// shared-ALU controller.
//   req0_* / req1_* : valid/ready request channels carrying op (Y86 ifun) and
//                     64-bit operands a, b.
//   rsp_*           : valid/ready response channel with requester id, result
//                     and {ZF, SF, OF}.
// master modport: requesters and response consumer side.
// slave modport : the controller (alu_share_ctrl).
interface alu_share_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [1:0]  req0_op;
    logic [63:0] req0_a;
    logic [63:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [1:0]  req1_op;
    logic [63:0] req1_a;
    logic [63:0] req1_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [63:0] rsp_result;
    logic [2:0]  rsp_cc;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_cc
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_cc
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one 64-bit Y86-64 ALU (add/sub/and/xor) between two
// requesters. Round-robin grant in IDLE, one operation in flight, result and
// condition codes registered and held until the consumer accepts them.
//   gclk    : rising-edge clock
//   grst_n  : asynchronous active-low reset
//   bus     : alu_share_if.slave (request channels 0/1, response channel)
//   o_busy  : controller is not in IDLE
// Build option: ALU_CC_EN -- when defined, ZF/SF/OF are computed and
// registered; when undefined, rsp_cc is tied to 3'b000.
module alu_share_ctrl (
    input  logic        gclk,
    input  logic        grst_n,
    alu_share_if.slave  bus,
    output logic        o_busy
);
    typedef struct packed {
        logic        id;
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
    } req_t;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic        r_prio;
    req_t        r_req;
    logic        r_rsp_id;
    logic [63:0] r_rsp_result;

    logic [1:0]  w_vld;
    logic        w_gnt;
    logic        w_acc;
    req_t        w_sel;
    logic [63:0] w_res;

    // Priority pointer only matters on contention; otherwise the lone
    // valid requester wins (w_vld[1] picks req1 when only it is valid).
    assign w_vld = {bus.req1_valid, bus.req0_valid};
    assign w_gnt = (&w_vld) ? r_prio : w_vld[1];
    assign w_acc = (r_state == S_IDLE) && (|w_vld);

    assign bus.req0_ready = w_acc && !w_gnt;
    assign bus.req1_ready = w_acc &&  w_gnt;

    always_comb begin
        w_sel = '{id: 1'b0, op: bus.req0_op, a: bus.req0_a, b: bus.req0_b};
        if (w_gnt)
            w_sel = '{id: 1'b1, op: bus.req1_op, a: bus.req1_a, b: bus.req1_b};
    end

    always_comb begin
        w_res = '0;
        case (r_req.op)
            2'd0: w_res = r_req.a + r_req.b;
            2'd1: w_res = r_req.a - r_req.b;
            2'd2: w_res = r_req.a & r_req.b;
            2'd3: w_res = r_req.a ^ r_req.b;
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            r_state      <= S_IDLE;
            r_prio       <= 1'b0;
            r_req        <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_req   <= w_sel;
                        r_prio  <= ~w_gnt;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_id     <= r_req.id;
                    r_rsp_result <= w_res;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_CC_EN
    logic [2:0] w_cc;
    logic [2:0] r_rsp_cc;

    // OF: add overflows when like-signed operands give a differently signed
    // result; sub when unlike-signed operands do. Logic ops never overflow.
    always_comb begin
        w_cc[2] = (w_res == 64'd0);
        w_cc[1] = w_res[63];
        case (r_req.op)
            2'd0:    w_cc[0] = (r_req.a[63] == r_req.b[63]) && (w_res[63] != r_req.a[63]);
            2'd1:    w_cc[0] = (r_req.a[63] != r_req.b[63]) && (w_res[63] != r_req.a[63]);
            default: w_cc[0] = 1'b0;
        endcase
    end

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)
            r_rsp_cc <= 3'b000;
        else if (r_state == S_EXEC)
            r_rsp_cc <= w_cc;
    end

    assign bus.rsp_cc = r_rsp_cc;
`else
    assign bus.rsp_cc = 3'b000;
`endif

    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign o_busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;
    logic gclk = 1'b0;
    logic grst_n = 1'b0;
    logic busy;

    alu_share_if bus();

    alu_share_ctrl dut (
        .gclk   (gclk),
        .grst_n (grst_n),
        .bus    (bus),
        .o_busy (busy)
    );

    always #5 gclk = ~gclk;

    int cyc = 0;
    always @(posedge gclk) cyc <= cyc + 1;

    typedef struct {
        logic        id;
        logic [63:0] res;
        logic [2:0]  cc;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    bit   run = 0;
    bit   m_busy = 0;
    bit   m_prio = 0;
    int   hold_left = 0;
    int   rdy_mode = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference ALU: 65-bit sign-extended arithmetic, overflow when the
    // top two bits of the wide result disagree.
    function automatic void model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic [2:0] cc);
        logic [64:0] w;
        logic        of;
        case (op)
            2'd0:    w = {a[63], a} + {b[63], b};
            2'd1:    w = {a[63], a} - {b[63], b};
            2'd2:    w = {1'b0, a & b};
            default: w = {1'b0, a ^ b};
        endcase
        r  = w[63:0];
        of = (op < 2'd2) ? (w[64] ^ w[63]) : 1'b0;
`ifdef ALU_CC_EN
        cc = {(r == 64'd0), r[63], of};
`else
        cc = 3'b000;
`endif
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return {64{1'b1}};
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One stimulus cycle: drive inputs, check readies against the arbitration
    // rules, and on a grant push the expected response.
    task automatic drive(input logic v0, input logic [1:0] op0, input logic [63:0] a0, input logic [63:0] b0,
                         input logic v1, input logic [1:0] op1, input logic [63:0] a1, input logic [63:0] b1,
                         output bit acc);
        bit          g;
        logic        e0, e1;
        logic [63:0] r;
        logic [2:0]  cc;
        @(negedge gclk);
        bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
        #2;
        e0 = 1'b0; e1 = 1'b0; g = 1'b0; acc = 1'b0;
        if (!m_busy && (v0 || v1)) begin
            g  = (v0 && v1) ? m_prio : v1;
            e0 = !g;
            e1 = g;
        end
        chk("req0_ready", {63'd0, bus.req0_ready}, {63'd0, e0});
        chk("req1_ready", {63'd0, bus.req1_ready}, {63'd0, e1});
        if (e0 || e1) begin
            if (g) model(op1, a1, b1, r, cc);
            else   model(op0, a0, b0, r, cc);
            exp_q.push_back('{id: g, res: r, cc: cc, acc: cyc});
            m_busy = 1'b1;
            m_prio = !g;
            acc    = 1'b1;
        end
    endtask

    task automatic issue(input logic v0, input logic [1:0] op0, input logic [63:0] a0, input logic [63:0] b0,
                         input logic v1, input logic [1:0] op1, input logic [63:0] a1, input logic [63:0] b1);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++)
            drive(v0, op0, a0, b0, v1, op1, a1, b1, acc);
        if (!acc) chk("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++)
            drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 2'd0, 64'd0, 64'd0, acc);
    endtask

    // Monitor / consumer: drives rsp_ready, compares the response channel
    // against the head of the scoreboard queue.
    initial begin
        logic ev, eb;
        wait (run);
        forever begin
            @(negedge gclk);
            bus.rsp_ready = (hold_left > 0) ? 1'b0 :
                            (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            #3;
            ev = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + 2);
            eb = (exp_q.size() > 0) && (cyc > exp_q[0].acc);
            chk("rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, ev});
            chk("busy", {63'd0, busy}, {63'd0, eb});
            if (ev) begin
                chk("rsp_id", {63'd0, bus.rsp_id}, {63'd0, exp_q[0].id});
                chk("rsp_result", bus.rsp_result, exp_q[0].res);
                chk("rsp_cc", {61'd0, bus.rsp_cc}, {61'd0, exp_q[0].cc});
                if (bus.rsp_ready) begin
                    void'(exp_q.pop_front());
                    m_busy = 1'b0;
                end
            end
            if (bus.rsp_valid && hold_left > 0) hold_left--;
        end
    end

    initial begin
        bit acc;
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.rsp_ready  = 1;

        // Reset values
        #1;
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rsp_result", bus.rsp_result, 64'd0);
        chk("rst_rsp_id", {63'd0, bus.rsp_id}, 64'd0);
        chk("rst_rsp_cc", {61'd0, bus.rsp_cc}, 64'd0);
        @(negedge gclk) grst_n = 1'b1;

        // Reset in the middle of EXEC discards the operation
        @(negedge gclk);
        bus.req0_valid = 1; bus.req0_op = 2'd0; bus.req0_a = 64'd3; bus.req0_b = 64'd4;
        #2 chk("mid_rst_accept", {63'd0, bus.req0_ready}, 64'd1);
        @(negedge gclk);
        bus.req0_valid = 0;
        chk("mid_rst_exec_busy", {63'd0, busy}, 64'd1);
        grst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("mid_rst_rsp_result", bus.rsp_result, 64'd0);
        @(negedge gclk);
        grst_n = 1'b1;
        bus.req0_valid = 1; bus.req1_valid = 1;
        #2;
        chk("mid_rst_prio_r0", {63'd0, bus.req0_ready}, 64'd1);
        chk("mid_rst_prio_r1", {63'd0, bus.req1_ready}, 64'd0);
        #1;
        bus.req0_valid = 0; bus.req1_valid = 0;

        run = 1;
        m_busy = 0;
        m_prio = 0;

        // add overflow into the sign bit
        issue(1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 2'd0, 64'd0, 64'd0);
        idle(4);
        // and with sign bit set
        issue(1, 2'd2, 64'h8000_0000_0000_0000, {64{1'b1}}, 0, 2'd0, 64'd0, 64'd0);
        idle(4);

        // Back-pressure: consumer stalls 4 cycles while both requesters wait
        hold_left = 4;
        issue(0, 2'd0, 64'd0, 64'd0, 1, 2'd3, 64'h1234, 64'h00FF);
        for (int i = 0; i < 10; i++)
            drive(1, 2'd1, 64'd0, 64'd1, 1, 2'd0, 64'd9, 64'd9, acc);
        idle(4);

        // Contention every cycle: grants must alternate
        for (int i = 0; i < 14; i++)
            drive(1, 2'd3, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                  1, 2'd1, 64'd5, 64'd14, acc);
        idle(4);

        // Randomized traffic with a randomly stalling consumer
        rdy_mode = 1;
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), pick(), pick(),
                  1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), pick(), pick(), acc);
        rdy_mode = 0;
        idle(10);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
